card_deal_controller: RTL and testbench
=======================================

# card_deal_controller

Sequences the free-running random number generator into a 52-card deck dealer for the BlackJack datapath. Player and dealer requests are arbitrated round-robin, one RNG sample is captured per deal, and a used-card bitmap prevents duplicates. Each deal returns a unique card index, rank and suit. The controller sits between the game FSM (requesters) and the RNG, whose `i_max` it drives.

## Interface
- `DECK_SIZE`, default 52: cards per deck; legal card indices are 0..DECK_SIZE-1.
- `RNG_WIDTH`, default 6: RNG value width; must satisfy 2^RNG_WIDTH >= DECK_SIZE.

- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req`  in  2  deal requests; bit0 = player, bit1 = dealer.
- `i_shuffle`  in  1  clears the dealt-card bitmap and the dealt count.
- `i_rng_value`  in  RNG_WIDTH  current RNG output.
- `o_rng_max`  out  RNG_WIDTH  constant DECK_SIZE-1, drives the RNG `i_max`.
- `o_grant`  out  2  one-hot, one-cycle pulse; identifies which requester receives the card.
- `o_card`  out  6  card index 0..51; valid only while `o_grant` != 0.
- `o_rank`  out  4  1..13 (1 = ace, 11..13 = J/Q/K); `o_card` mod 13, plus 1.
- `o_suit`  out  2  `o_card` / 13.
- `o_busy`  out  1  high in every state except IDLE.
- `o_deck_empty`  out  1  high when dealt count == DECK_SIZE.
- `o_dealt_count`  out  6  number of cards dealt since reset or shuffle.

## Operation
- **States:** IDLE, SAMPLE, CHECK, PROBE, GRANT.
- **IDLE:**
  - Pending shuffle (`i_shuffle` now, or latched earlier) has priority. It clears the bitmap and count in one cycle, clears the latch, and the FSM stays in IDLE.
  - Otherwise, if any `i_req` bit is set and the deck is not empty, arbitrate and go to SAMPLE.
  - While the deck is empty, requests are ignored (not latched); no grant is issued.
- **Arbitration:**
  - Round-robin on a last-granted pointer. The pointer resets to dealer, so the player wins the first tie.
  - A single requester always wins.
  - The winner is latched. The grant is delivered even if that `i_req` bit drops afterwards.
- **SAMPLE:**
  - Capture `i_rng_value` into the candidate register.
  - If the value is >= DECK_SIZE, subtract DECK_SIZE; if it is still out of range, use 0.
  - Go to CHECK.
- **CHECK:**
  - If the candidate's bitmap bit is clear, go to GRANT.
  - Otherwise candidate = (candidate+1) wrapping DECK_SIZE-1 to 0, and go to PROBE.
- **PROBE:**
  - Same test as CHECK; repeat until a free card is found.
  - Bounded: the deck is not empty, so at most DECK_SIZE-1 probes are needed.
- **GRANT:**
  - Drive `o_grant`, `o_card`, `o_rank`, `o_suit`.
  - Set the bitmap bit, increment the count, update the round-robin pointer, go to IDLE.
- **Shuffle while busy:** `i_shuffle` is latched and applied on the next IDLE cycle. The in-flight deal completes first.
- **Simultaneous events in IDLE:** with shuffle and request together, shuffle is taken first and the request is served in the following cycle (if still asserted).
- **Handshake rule:** a requester must deassert its `i_req` bit in the cycle after its grant. A bit still high in IDLE is treated as a new request.

## Timing
- **Reset:**
  - State IDLE, bitmap all 0, count 0, shuffle latch 0, pointer = dealer.
  - `o_grant` = 0, `o_card` = 0, `o_rank` = 0, `o_suit` = 0, `o_busy` = 0, `o_deck_empty` = 0, `o_dealt_count` = 0.
  - `o_rng_max` = DECK_SIZE-1 at all times.
- **Latency:**
  - Request seen in IDLE at edge N: SAMPLE at N+1, CHECK at N+2, `o_grant` high during cycle N+3 when there is no collision.
  - Each PROBE adds one cycle.
  - Back-to-back deals: minimum 4 cycles per card.
- **Registered outputs:** `o_card`, `o_rank` and `o_suit` are registered, valid only during the grant cycle, and return to 0 afterwards.
- `o_dealt_count` and `o_deck_empty` update in the cycle after GRANT.
- **Reset mid-operation:** reset in any state returns everything to reset values on the next edge. No grant is issued for the aborted deal.

## Test plan
- **Reset, single request:** reset, then `i_rng_value` = 17, `i_req` = 01 → `o_grant` = 01 three cycles later, `o_card` = 17, `o_rank` = 5, `o_suit` = 1, `o_dealt_count` = 1.
- **Collision probe:** deal card 30, then request again with `i_rng_value` held at 30 → `o_card` = 31, grant at 4 cycles of latency. Repeat with cards 51 and 0 used and RNG = 51 → `o_card` = 1 (wrap).
- **Round-robin:** `i_req` = 11 held, each bit dropped after its grant → grants alternate player (01), dealer (10), player (01).
- **Out-of-range RNG:** `i_rng_value` = 60 → `o_card` = 8. Separately, 52 → `o_card` = 0.
- **Deck exhaustion and shuffle:** deal 52 cards → `o_deck_empty` = 1 and a further request gets no grant for 10 cycles. Pulse `i_shuffle` → count 0, `o_deck_empty` = 0, and the next request is granted.
- **Shuffle or reset mid-deal:** `i_shuffle` in SAMPLE → the current deal completes, then the bitmap clears and count = 0. `i_reset` in CHECK → no grant, all outputs at reset values next cycle.

Source files
------------

// File: rtl/card_deal_controller.sv
// Deals unique cards from a DECK_SIZE deck: round-robin player/dealer arbitration,
// one RNG sample per deal, linear probing over a used-card bitmap.
module card_deal_controller #(
    parameter int DECK_SIZE = 52,
    parameter int RNG_WIDTH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_req,
    input  logic                 i_shuffle,
    input  logic [RNG_WIDTH-1:0] i_rng_value,
    output logic [RNG_WIDTH-1:0] o_rng_max,
    output logic [1:0]           o_grant,
    output logic [5:0]           o_card,
    output logic [3:0]           o_rank,
    output logic [1:0]           o_suit,
    output logic                 o_busy,
    output logic                 o_deck_empty,
    output logic [5:0]           o_dealt_count
);

    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, PROBE, GRANT} state_t;

    localparam logic [5:0] LAST_CARD = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL      = 6'(DECK_SIZE);

    state_t               state, state_next;
    logic [DECK_SIZE-1:0] bitmap;
    logic [5:0]           cand, cand_next, count;
    logic [1:0]           winner, pick;
    logic                 last_dealer, pend, shuffle_now, hit, deck_empty;
    logic [1:0]           grant_q, suit_q;
    logic [5:0]           card_q;
    logic [3:0]           rank_q;

    // One subtraction covers RNG values up to 2*DECK_SIZE-1; anything beyond maps to 0.
    function automatic logic [5:0] fold(input logic [RNG_WIDTH-1:0] v);
        logic [31:0] x;
        x = 32'(v);
        if (x >= 32'(DECK_SIZE)) x = x - 32'(DECK_SIZE);
        if (x >= 32'(DECK_SIZE)) x = '0;
        return 6'(x);
    endfunction

    assign deck_empty = (count == FULL);
    assign hit        = !bitmap[cand];

    always_comb begin
        state_next  = state;
        cand_next   = cand;
        pick        = '0;
        shuffle_now = 1'b0;
        case (state)
            IDLE: begin
                if (i_shuffle || pend) begin
                    shuffle_now = 1'b1;
                end else if (i_req != 2'b00 && !deck_empty) begin
                    state_next = SAMPLE;
                    case (i_req)
                        2'b01:   pick = 2'b01;
                        2'b10:   pick = 2'b10;
                        default: pick = last_dealer ? 2'b01 : 2'b10;
                    endcase
                end
            end
            SAMPLE: begin
                cand_next  = fold(i_rng_value);
                state_next = CHECK;
            end
            CHECK, PROBE: begin
                if (hit) begin
                    state_next = GRANT;
                end else begin
                    cand_next  = (cand == LAST_CARD) ? '0 : cand + 6'd1;
                    state_next = PROBE;
                end
            end
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cand        <= '0;
            winner      <= '0;
            bitmap      <= '0;
            count       <= '0;
            pend        <= 1'b0;
            last_dealer <= 1'b1;
            grant_q     <= '0;
            card_q      <= '0;
            rank_q      <= '0;
            suit_q      <= '0;
        end else begin
            state   <= state_next;
            cand    <= cand_next;
            grant_q <= '0;
            card_q  <= '0;
            rank_q  <= '0;
            suit_q  <= '0;
            if (state == IDLE && state_next == SAMPLE) winner <= pick;
            if (shuffle_now) begin
                bitmap <= '0;
                count  <= '0;
                pend   <= 1'b0;
            end else if (i_shuffle && state != IDLE) begin
                pend <= 1'b1;
            end
            // Outputs are loaded on entry to GRANT so they are valid exactly for that cycle.
            if ((state == CHECK || state == PROBE) && hit) begin
                grant_q <= winner;
                card_q  <= cand;
                rank_q  <= 4'(cand % 6'd13) + 4'd1;
                suit_q  <= 2'(cand / 6'd13);
            end
            if (state == GRANT) begin
                bitmap[card_q] <= 1'b1;
                count          <= count + 6'd1;
                last_dealer    <= winner[1];
            end
        end
    end

    assign o_rng_max     = RNG_WIDTH'(DECK_SIZE - 1);
    assign o_grant       = grant_q;
    assign o_card        = card_q;
    assign o_rank        = rank_q;
    assign o_suit        = suit_q;
    assign o_busy        = (state != IDLE);
    assign o_deck_empty  = deck_empty;
    assign o_dealt_count = count;

endmodule

// File: tb/tb_card_deal_controller.sv
// Directed bench for card_deal_controller: latency, probing, round-robin, exhaustion,
// shuffle and reset behaviour against hand-computed expectations.
module tb_card_deal_controller;

    logic       clk = 1'b0;
    logic       i_reset, i_shuffle;
    logic [1:0] i_req;
    logic [5:0] i_rng_value;
    logic [5:0] o_rng_max, o_card, o_dealt_count;
    logic [1:0] o_grant, o_suit;
    logic [3:0] o_rank;
    logic       o_busy, o_deck_empty;

    int n_cmp = 0;
    int n_err = 0;
    logic used [52];

    card_deal_controller #(.DECK_SIZE(52), .RNG_WIDTH(6)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_shuffle(i_shuffle),
        .i_rng_value(i_rng_value), .o_rng_max(o_rng_max), .o_grant(o_grant),
        .o_card(o_card), .o_rank(o_rank), .o_suit(o_suit), .o_busy(o_busy),
        .o_deck_empty(o_deck_empty), .o_dealt_count(o_dealt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_card"}, o_card, 0);
        check({tag, "_rank"}, o_rank, 0);
        check({tag, "_suit"}, o_suit, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_empty"}, o_deck_empty, 0);
        check({tag, "_count"}, o_dealt_count, 0);
        check({tag, "_max"}, o_rng_max, 51);
    endtask

    // Ends in the IDLE cycle after the grant, with the granted request bit dropped.
    task automatic deal(input string tag, input logic [1:0] req, input logic [5:0] rng,
                        input logic [1:0] exp_grant, input int exp_card, input int exp_lat);
        int lat;
        i_req = req;
        i_rng_value = rng;
        lat = 0;
        tick();
        lat++;
        check({tag, "_busy"}, o_busy, 1);
        while (o_grant == 2'b00 && lat < 80) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_grant"}, o_grant, exp_grant);
        check({tag, "_card"}, o_card, exp_card);
        check({tag, "_rank"}, o_rank, exp_card % 13 + 1);
        check({tag, "_suit"}, o_suit, exp_card / 13);
        i_req = req & ~o_grant;
        tick();
        check({tag, "_after"}, {o_grant, o_card}, 0);
        used[exp_card] = 1'b1;
    endtask

    initial begin
        int c, seen, cnt;
        int pre [10] = '{17, 30, 31, 51, 0, 1, 40, 2, 3, 4};

        foreach (used[k]) used[k] = 1'b0;
        i_reset = 1'b1; i_shuffle = 1'b0; i_req = 2'b00; i_rng_value = '0;
        tick(); tick();
        check_idle_reset("reset");
        i_reset = 1'b0;
        tick();

        deal("single", 2'b01, 6'd17, 2'b01, 17, 3);
        check("single_rank_hand", 5, 5);
        check("single_count", o_dealt_count, 1);
        check("single_idle", o_busy, 0);

        deal("c30", 2'b01, 6'd30, 2'b01, 30, 3);
        deal("probe1", 2'b01, 6'd30, 2'b01, 31, 4);
        deal("c51", 2'b01, 6'd51, 2'b01, 51, 3);
        deal("c0", 2'b01, 6'd0, 2'b01, 0, 3);
        deal("wrap", 2'b01, 6'd51, 2'b01, 1, 5);

        deal("dealer", 2'b10, 6'd40, 2'b10, 40, 3);
        deal("rr1", 2'b11, 6'd2, 2'b01, 2, 3);
        deal("rr2", 2'b11, 6'd3, 2'b10, 3, 3);
        deal("rr3", 2'b11, 6'd4, 2'b01, 4, 3);
        check("rr_count", o_dealt_count, 10);

        cnt = 0;
        foreach (pre[k]) if (used[pre[k]]) cnt++;
        check("model_used", cnt, 10);

        for (int n = 0; n < 42; n++) begin
            c = 0;
            while (used[c]) c++;
            deal("fill", 2'b01, 6'd0, 2'b01, c, 3 + c);
        end
        check("full_count", o_dealt_count, 52);
        check("full_empty", o_deck_empty, 1);

        i_req = 2'b01;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            seen = seen | int'(o_grant) | int'(o_busy);
        end
        check("empty_nogrant", seen, 0);
        i_req = 2'b00;

        i_shuffle = 1'b1;
        tick();
        i_shuffle = 1'b0;
        check("shuf_count", o_dealt_count, 0);
        check("shuf_empty", o_deck_empty, 0);
        foreach (used[k]) used[k] = 1'b0;

        deal("oor52", 2'b01, 6'd52, 2'b01, 0, 3);
        deal("oor60", 2'b01, 6'd60, 2'b01, 8, 3);

        i_req = 2'b01; i_rng_value = 6'd20;
        tick();
        i_shuffle = 1'b1;
        tick();
        i_shuffle = 1'b0;
        tick();
        check("midshuf_grant", o_grant, 1);
        check("midshuf_card", o_card, 20);
        i_req = 2'b00;
        tick();
        check("midshuf_count3", o_dealt_count, 3);
        tick();
        check("midshuf_count0", o_dealt_count, 0);
        foreach (used[k]) used[k] = 1'b0;
        deal("post_shuf", 2'b01, 6'd0, 2'b01, 0, 3);

        i_req = 2'b01; i_rng_value = 6'd10;
        tick();
        tick();
        check("midrst_busy", o_busy, 1);
        i_reset = 1'b1; i_req = 2'b00;
        tick();
        check_idle_reset("midrst");
        i_reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            seen = seen | int'(o_grant);
        end
        check("midrst_nogrant", seen, 0);
        foreach (used[k]) used[k] = 1'b0;
        deal("post_rst", 2'b01, 6'd0, 2'b01, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
